// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the iterative cipher core.
package aes_pkg;

    localparam int AES_BLOCK_W    = 128;
    localparam int AES_KEY_ADDR_W = 4;

    typedef logic [1:0] aes_state_t;
    localparam aes_state_t S_WAIT  = 2'd0;
    localparam aes_state_t S_IDLE  = 2'd1;
    localparam aes_state_t S_ROUND = 2'd2;
    localparam aes_state_t S_DONE  = 2'd3;

    // Output byte i of ShiftRows takes input byte SR_IDX[i] (column-major, byte 0 = MSB).
    localparam logic [3:0] SR_IDX [16] = '{
        4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3,
        4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6, 4'd11
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] blk, input logic [3:0] idx);
        return blk[8*(15-int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/aes_sbox_ram.sv
// Dual-port 256x8 AES S-box ROM, two lookups per cycle, registered outputs.
module aes_sbox_ram
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr_a,
    input  logic [7:0] addr_b,
    output logic [7:0] dout_a,
    output logic [7:0] dout_b
);
    localparam logic [0:255][7:0] ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_ff @(posedge clk) begin
        dout_a <= ROM[addr_a];
        dout_b <= ROM[addr_b];
    end

endmodule

// File: rtl/aes_iter_ram.sv
// Iterative AES encryption core; S-box lookups through BRAM ROMs, SBOX_LANES per cycle.
// Define AES_ERR_EN to add the sticky err_ovf flag for blocks offered while busy.
module aes_iter_ram
    import aes_pkg::*;
#(
    parameter int NR         = 10,
    parameter int SBOX_LANES = 8
) (
    input  logic                      clk,
    input  logic                      kill,
    input  logic [AES_BLOCK_W-1:0]    input_data,
    input  logic                      input_en,
    output logic                      input_rdy,
    output logic [AES_KEY_ADDR_W-1:0] key_addr,
    input  logic [AES_BLOCK_W-1:0]    key_round,
    output logic [AES_BLOCK_W-1:0]    output_data,
    output logic                      output_en
`ifdef AES_ERR_EN
    ,
    output logic                      err_ovf
`endif
);
    localparam int RC = 16 / SBOX_LANES + 1;

    aes_state_t                 fsm;
    logic [3:0]                 round_cnt;
    logic [2:0]                 phase;
    logic [AES_BLOCK_W-1:0]     st;
    logic [15:0][7:0]           sub;
    logic [15:0][7:0]           sub_all;
    logic [SBOX_LANES-1:0][7:0] sb_addr;
    logic [SBOX_LANES-1:0][7:0] sb_dout;
    logic [AES_BLOCK_W-1:0]     sub_blk;
    logic [AES_BLOCK_W-1:0]     mix_blk;
    logic [AES_BLOCK_W-1:0]     rnd_out;
    logic                       last_ph;
    logic                       last_rnd;

    assign input_rdy = (fsm == S_IDLE);
    assign output_en = (fsm == S_DONE);
    assign last_ph   = (phase == 3'(RC - 1));
    assign last_rnd  = (round_cnt == 4'(NR));

    for (genvar g = 0; g < SBOX_LANES / 2; g++) begin : g_sbox
        aes_sbox_ram u_sbox (
            .clk    (clk),
            .addr_a (sb_addr[2*g]),
            .addr_b (sb_addr[2*g+1]),
            .dout_a (sb_dout[2*g]),
            .dout_b (sb_dout[2*g+1])
        );
    end

    // Lane j of phase p looks up byte p*SBOX_LANES+j of the ShiftRows view of st.
    always_comb begin
        sb_addr = '0;
        for (int j = 0; j < SBOX_LANES; j++)
            sb_addr[j] = get_byte(st, SR_IDX[4'(int'(phase) * SBOX_LANES + j)]);
    end

    // The final group arrives in the last phase and is used straight off the ROM.
    always_comb begin
        sub_all = sub;
        for (int j = 0; j < SBOX_LANES; j++)
            sub_all[4'((RC - 2) * SBOX_LANES + j)] = sb_dout[j];
        sub_blk = '0;
        for (int k = 0; k < 16; k++)
            sub_blk[8*(15-k) +: 8] = sub_all[k];
        mix_blk = '0;
        for (int c = 0; c < 4; c++)
            mix_blk[32*(3-c) +: 32] = last_rnd ? sub_blk[32*(3-c) +: 32]
                                               : mix_column(sub_blk[32*(3-c) +: 32]);
        rnd_out = mix_blk ^ key_round;
    end

    always_ff @(posedge clk) begin
        if (fsm == S_ROUND && phase != 3'd0)
            for (int j = 0; j < SBOX_LANES; j++)
                sub[4'((int'(phase) - 1) * SBOX_LANES + j)] <= sb_dout[j];
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            fsm         <= S_WAIT;
            round_cnt   <= '0;
            phase       <= '0;
            key_addr    <= '0;
            output_data <= '0;
            st          <= '0;
        end else begin
            case (fsm)
                S_WAIT: fsm <= S_IDLE;
                S_IDLE: begin
                    if (input_en) begin
                        st        <= input_data ^ key_round;
                        round_cnt <= 4'd1;
                        key_addr  <= 4'd1;
                        phase     <= '0;
                        fsm       <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (last_ph) begin
                        st    <= rnd_out;
                        phase <= '0;
                        if (!last_rnd) begin
                            round_cnt <= round_cnt + 4'd1;
                            key_addr  <= key_addr + 4'd1;
                        end else begin
                            output_data <= rnd_out;
                            key_addr    <= '0;
                            fsm         <= S_DONE;
                        end
                    end else begin
                        phase <= phase + 3'd1;
                    end
                end
                S_DONE:  fsm <= S_IDLE;
                default: fsm <= S_WAIT;
            endcase
        end
    end

`ifdef AES_ERR_EN
    always_ff @(posedge clk) begin
        if (kill)
            err_ovf <= 1'b0;
        else if (input_en && !input_rdy)
            err_ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_aes_iter_ram.sv
// Bench for aes_iter_ram: five configurations, FIPS-197 vectors, random blocks vs a byte-matrix AES model.
module tb_aes_iter_ram;

    localparam int ND = 5;
    localparam int CFG_NR [ND] = '{10, 12, 14, 10, 10};
    localparam int CFG_LN [ND] = '{8, 8, 8, 4, 16};

    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         kill = 1'b1;
    int           cyc = 0;
    logic [127:0] din    [ND];
    logic         en     [ND];
    logic         rdy    [ND];
    logic [3:0]   kaddr  [ND];
    logic [127:0] kround [ND];
    logic [127:0] dout   [ND];
    logic         oen    [ND];
`ifdef AES_ERR_EN
    logic         err    [ND];
`endif
    logic [127:0] kram   [ND][16];
    logic [7:0]   sb_tab [256];
    int           n_cmp = 0;
    int           n_mis = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        aes_iter_ram #(.NR(CFG_NR[g]), .SBOX_LANES(CFG_LN[g])) u_dut (
            .clk         (clk),
            .kill        (kill),
            .input_data  (din[g]),
            .input_en    (en[g]),
            .input_rdy   (rdy[g]),
            .key_addr    (kaddr[g]),
            .key_round   (kround[g]),
            .output_data (dout[g]),
            .output_en   (oen[g])
`ifdef AES_ERR_EN
            ,
            .err_ovf     (err[g])
`endif
        );
        always @(posedge clk) kround[g] <= kram[g][kaddr[g]];
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] key, input int nr, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          nk = nr - 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Textbook cipher on a 4x4 byte matrix s[row][col].
    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [255:0] key, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] rk, res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(r+4*c) -: 8];
        for (int rd = 0; rd <= nr; rd++) begin
            if (rd > 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) t[r][c] = sb_tab[s[r][(c+r)%4]];
                for (int c = 0; c < 4; c++)
                    if (rd < nr) begin
                        s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
                        s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
                        s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
                        s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
                    end else begin
                        for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                    end
            end
            rk = round_key(key, nr, rd);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ rk[127-8*(r+4*c) -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127-8*(r+4*c) -: 8] = s[r][c];
        return res;
    endfunction

    task automatic load_key(input int k, input logic [255:0] key);
        for (int r = 0; r <= CFG_NR[k]; r++) kram[k][r] = round_key(key, CFG_NR[k], r);
    endtask

    task automatic wait_rdy(input int k, input string nm);
        int n = 0;
        while (!rdy[k] && n < 100) begin @(negedge clk); n++; end
        chk({nm, " rdy"}, 128'(rdy[k]), 128'd1);
    endtask

    task automatic run_block(input int k, input logic [255:0] key, input logic [127:0] pt,
                             input logic [127:0] exp_ct, input int exp_lat, input string nm);
        int n;
        load_key(k, key);
        @(negedge clk);
        wait_rdy(k, nm);
        din[k] = pt;
        en[k]  = 1'b1;
        @(negedge clk);
        en[k]  = 1'b0;
        din[k] = {$urandom, $urandom, $urandom, $urandom};
        n = 1;
        while (!oen[k] && n < 200) begin @(negedge clk); n++; end
        chk({nm, " lat"}, 128'(n), 128'(exp_lat));
        chk({nm, " ct"}, dout[k], exp_ct);
    endtask

    typedef struct {
        int           inst;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           lat;
    } vec_t;

    initial begin
        vec_t         vt [6];
        logic [255:0] rkey;
        logic [127:0] p1, p2, e1, e2, o1;
        int           n, t1, t2, k, seen;

        vt[0] = '{0, KEY_B,  PT_B, CT_B, 31};
        vt[1] = '{0, KEY_C1, PT_C, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 31};
        vt[2] = '{1, KEY_C2, PT_C, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 37};
        vt[3] = '{2, KEY_C3, PT_C, 128'h8ea2b7ca516745bfeafc49904b496089, 43};
        vt[4] = '{3, KEY_B,  PT_B, CT_B, 51};
        vt[5] = '{4, KEY_B,  PT_B, CT_B, 21};

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < ND; i++) begin
            en[i]  = 1'b0;
            din[i] = '0;
            for (int r = 0; r < 16; r++) kram[i][r] = '0;
        end

        // Reset state and release timing.
        repeat (3) @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("rst rdy%0d", i), 128'(rdy[i]), 128'd0);
            chk($sformatf("rst oen%0d", i), 128'(oen[i]), 128'd0);
            chk($sformatf("rst dout%0d", i), dout[i], 128'd0);
            chk($sformatf("rst kaddr%0d", i), 128'(kaddr[i]), 128'd0);
`ifdef AES_ERR_EN
            chk($sformatf("rst err%0d", i), 128'(err[i]), 128'd0);
`endif
        end
        kill = 1'b0;
        chk("rel rdy c1", 128'(rdy[0]), 128'd0);
        @(negedge clk);
        chk("rel rdy c2", 128'(rdy[0]), 128'd1);

        for (int i = 0; i < 6; i++)
            run_block(vt[i].inst, vt[i].key, vt[i].pt, vt[i].ct, vt[i].lat, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            k    = $urandom_range(0, ND - 1);
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            p1   = {$urandom, $urandom, $urandom, $urandom};
            run_block(k, rkey, p1, model_enc(p1, rkey, CFG_NR[k]),
                      CFG_NR[k] * (16 / CFG_LN[k] + 1) + 1, $sformatf("rnd%0d", i));
        end

        // Back-to-back with input_en held high.
        load_key(0, KEY_C1);
        @(negedge clk);
        wait_rdy(0, "b2b");
        p1 = PT_C;
        p2 = {$urandom, $urandom, $urandom, $urandom};
        e1 = model_enc(p1, KEY_C1, 10);
        e2 = model_enc(p2, KEY_C1, 10);
        din[0] = p1;
        en[0]  = 1'b1;
        t1 = cyc;
        @(negedge clk);
        din[0] = p2;
        n = 0;
        seen = 0;
        o1 = '0;
        while (!rdy[0] && n < 100) begin
            @(negedge clk);
            n++;
            if (oen[0]) begin seen = 1; o1 = dout[0]; end
        end
        t2 = cyc;
        chk("b2b spacing", 128'(t2 - t1), 128'd32);
        chk("b2b got1", 128'(seen), 128'd1);
        chk("b2b ct1", o1, e1);
        chk("b2b hold", dout[0], e1);
        @(negedge clk);
        en[0] = 1'b0;
        n = 1;
        while (!oen[0] && n < 200) begin @(negedge clk); n++; end
        chk("b2b lat2", 128'(n), 128'd31);
        chk("b2b ct2", dout[0], e2);

        // Kill during round 5.
        load_key(0, KEY_B);
        @(negedge clk);
        wait_rdy(0, "kill");
        din[0] = PT_B;
        en[0]  = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        repeat (13) @(negedge clk);
        chk("kill kaddr r5", 128'(kaddr[0]), 128'd5);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill rdy c1", 128'(rdy[0]), 128'd0);
        chk("kill dout", dout[0], 128'd0);
        chk("kill kaddr", 128'(kaddr[0]), 128'd0);
        @(negedge clk);
        chk("kill rdy c2", 128'(rdy[0]), 128'd1);
        seen = 0;
        repeat (40) begin
            if (oen[0]) seen = 1;
            @(negedge clk);
        end
        chk("kill no oen", 128'(seen), 128'd0);
        run_block(0, KEY_C1, PT_C, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 31, "post kill");

        // Block offered while busy must be ignored.
        load_key(3, KEY_B);
        @(negedge clk);
        wait_rdy(3, "ovf");
        din[3] = PT_B;
        en[3]  = 1'b1;
        @(negedge clk);
        en[3] = 1'b0;
        repeat (10) @(negedge clk);
        din[3] = ~PT_B;
        en[3]  = 1'b1;
        @(negedge clk);
        en[3] = 1'b0;
`ifdef AES_ERR_EN
        chk("ovf err set", 128'(err[3]), 128'd1);
`endif
        n = 0;
        while (!oen[3] && n < 200) begin @(negedge clk); n++; end
        chk("ovf ct", dout[3], CT_B);
        @(negedge clk);
        chk("ovf rdy after", 128'(rdy[3]), 128'd1);
`ifdef AES_ERR_EN
        chk("ovf err held", 128'(err[3]), 128'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("ovf err clr", 128'(err[3]), 128'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/aes_iter_ram.md
# aes_iter_ram

Parametrised iterative AES encryption core: one 128-bit block in, one ciphertext block out. Supports AES-128/192/256 via round count, with S-box lookups in block-RAM ROMs at a configurable number of lookups per cycle. Sits between the block-framing logic and the output buffer. Round keys come from an external synchronous key RAM filled by the key-expansion block.

## Interface
- NR, 10, round count: 10, 12 or 14 (AES-128/192/256); other values are illegal.
- SBOX_LANES, 8, S-box lookups per cycle: 4, 8 or 16; must be even.
- clk  in  1  clock, all logic rising-edge.
- kill  in  1  reset, synchronous, active-high.
- input_data  in  128  plaintext; byte 0 = [127:120], FIPS-197 column-major.
- input_en  in  1  block valid; accepted only in a cycle where input_rdy=1.
- input_rdy  out  1  core can accept a block this cycle.
- key_addr  out  4  round-key RAM read address.
- key_round  in  128  round key; RAM registered read, valid 1 cycle after key_addr.
- output_data  out  128  ciphertext; held until next completion.
- output_en  out  1  one-cycle pulse, output_data valid.

## Operation
- States: WAIT, IDLE, ROUND, DONE. RC = 16/SBOX_LANES + 1 cycles per round (5/3/2).
- Reset (kill) from any state, including mid-round: state=WAIT, round_cnt=0, phase=0, key_addr=0, input_rdy=0, output_en=0, output_data=0. The in-flight block is discarded silently, with no output_en.
- WAIT: single cycle in which key0 is being fetched. Then go to IDLE.
- IDLE: input_rdy=1, key_addr=0, key_round=key0. On input_en: state <= input_data ^ key_round, round_cnt=1, key_addr=1, phase=0, go to ROUND.
- ROUND:
  - Phases 0..RC-2 issue S-box reads for byte group p, bytes p*SBOX_LANES.. of the ShiftRows-permuted state.
  - Phases 1..RC-1 capture the returned group p-1.
  - Phase RC-1: MixColumns (skipped when round_cnt==NR), then XOR key_round, then write state.
  - If round_cnt<NR: round_cnt+1, key_addr+1, phase=0.
  - Else: output_data <= result, key_addr=0, go to DONE.
- DONE: output_en=1, input_rdy=0. Then go to IDLE. key0 is fetched during this cycle.
- input_en while input_rdy=0 is ignored and does not alter the state.
- key_addr holds round_cnt for the whole round. key_round is consumed only in phase RC-1.
- GF(2^8) arithmetic uses xtime modulo 0x11b. All datapath bytes are 8 bits, with no carries.

## Timing
- Accept at cycle T → output_en at T+1+NR*RC. Default (NR=10, RC=3): T+31.
- Back-to-back blocks: input_rdy returns the cycle after output_en. Minimum accept spacing is NR*RC+2 (32 at default).
- After kill deasserts: input_rdy=1 on the second cycle.
- S-box ROM read latency is exactly 1 cycle, with no output register beyond the BRAM.

## Configuration
- AES_ERR_EN defined: adds output port err_ovf (1 bit).
  - Sticky; set when input_en=1 and input_rdy=0.
  - Cleared only by kill; reset value 0.
- Undefined: no err_ovf port; dropped inputs are not recorded.

## Structure
- Package aes_pkg:
  - State enum (WAIT/IDLE/ROUND/DONE).
  - Constants AES_BLOCK_W=128 and AES_KEY_ADDR_W=4.
  - Function xtime and function mix_column (32→32).
  - ShiftRows index table (16 entries).
- Sub-module aes_sbox_ram: dual-port 256×8 ROM with 2 lookups per cycle and registered outputs. Instantiated SBOX_LANES/2 times.

## Test plan
- Bench key-RAM model holds expanded keys (registered read). FIPS-197 B: NR=10, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → output 3925841d02dc09fbdc118597196a0b32, output_en exactly 31 cycles after accept.
- FIPS-197 C.1/C.2/C.3:
  - pt 00112233445566778899aabbccddeeff with key 000102…(16/24/32 bytes).
  - NR=10 → 69c4e0d86a7b0430d8cdb78070b4c55a.
  - NR=12 → dda97ca4864cdfe06eaf70a0ec0d7191.
  - NR=14 → 8ea2b7ca516745bfeafc49904b496089.
- SBOX_LANES=4 and 16 with vector B: same ciphertext, latency 51 and 21 cycles.
- Back-to-back: hold input_en high with two different blocks. The second block is accepted exactly 32 cycles after the first, and both outputs are correct.
- kill pulsed in round 5: no output_en follows. input_rdy=1 two cycles after kill drops, and a fresh block then produces the correct ciphertext.
- AES_ERR_EN: input_en pulsed mid-operation → err_ovf=1 and held, first result unaffected; kill → err_ovf=0.
